div_unit: RTL
=============

Name: div_unit

Overview:
- Sequential signed 32-bit divider for the CPU's DIV instruction; the inverse-operation companion to the Booth multiplier.
- Shares the multiplier's start/done handshake and its Hi/Lo output pair.
- Results: outLo = quotient, truncated toward zero; outHi = remainder, carrying the sign of the dividend (MIPS semantics).
- Uses a restoring shift-subtract algorithm on operand magnitudes, one bit per cycle, followed by a sign-correction step.

Parameters:
WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
clock  input  1  system clock, rising-edge active
resetDiv  input  1  asynchronous, active-high reset
DoDiv  input  1  start request; sampled only in IDLE
A  input  WIDTH  dividend, two's complement
B  input  WIDTH  divisor, two's complement
endDiv  output  1  one-cycle done pulse; results valid from this cycle
divZero  output  1  one-cycle pulse when a start is requested with B == 0
outHi  output  WIDTH  remainder
outLo  output  WIDTH  quotient

Behaviour:
- Clock/reset (decided): one clock, clock; reset resetDiv is asynchronous, active-high.
- Reset: state=IDLE; outHi=0, outLo=0, endDiv=0, divZero=0; internal counter, remainder and quotient registers = 0.
- Reset during CALC or FIX aborts the operation. No endDiv pulse follows.
- States: IDLE, CALC, FIX.
- IDLE, DoDiv=1 and B!=0 at edge k:
  - latch |A| and |B| as unsigned values.
  - latch sign flags: qneg = A[31]^B[31]; rneg = A[31].
  - clear the remainder register; counter=0; go to CALC.
- IDLE, DoDiv=1 and B==0 at edge k:
  - divZero=1 for exactly one cycle; stay in IDLE.
  - outHi/outLo hold their previous values; endDiv stays 0.
- CALC, edges k+1..k+WIDTH, one iteration per edge:
  - shift {rem, dividend} left by 1.
  - trial = rem - |B| in WIDTH+1 bits.
  - if trial is non-negative: rem = trial and quotient bit = 1; otherwise restore and quotient bit = 0.
  - counter increments each edge; after the WIDTH-th iteration go to FIX.
- FIX, edge k+WIDTH+1:
  - outLo = qneg ? -quotient : quotient.
  - outHi = rneg ? -rem : rem.
  - endDiv=1 for one cycle; go to IDLE.
- Latency: endDiv is high in the cycle following edge k+33 (WIDTH=32), i.e. 33 edges after the start edge.
- endDiv and divZero are cleared on the edge after they rise. Both are registered outputs.
- DoDiv is ignored in CALC and FIX (no restart, no queuing).
- DoDiv held high continuously:
  - the next operation starts on the first edge in IDLE, i.e. the edge that clears endDiv.
  - A and B are re-sampled on that edge.
- A and B may change freely after the start edge; operands are captured.
- Magnitudes are computed in WIDTH bits as unsigned, so |0x80000000| = 0x80000000.
- Overflow case 0x80000000 / 0xFFFFFFFF: outLo = 0x80000000, outHi = 0. No flag is raised.
- Dividend 0 gives outLo=0 and outHi=0 for any nonzero B. |A| < |B| gives outLo=0 and outHi=A.
- Outputs hold their last values between operations and change only at FIX, or at reset.

Test Plan:
- Reset, then A=100, B=7, DoDiv pulse -> endDiv is a single pulse 33 edges after start; outLo=14, outHi=2; divZero stays 0 throughout.
- Sign cases:
  - A=-100, B=7 -> outLo=0xFFFFFFF2, outHi=0xFFFFFFFE.
  - A=100, B=-7 -> outLo=0xFFFFFFF2, outHi=2.
  - A=-100, B=-7 -> outLo=14, outHi=0xFFFFFFFE.
- Divide by zero: first run A=9, B=2 (outLo=4, outHi=1), then A=5, B=0 -> divZero pulses one cycle after start; endDiv never pulses; outLo=4 and outHi=1 are retained.
- Boundaries, each returning endDiv after 33 edges:
  - A=0x80000000, B=0xFFFFFFFF -> outLo=0x80000000, outHi=0.
  - A=3, B=10 -> outLo=0, outHi=3.
  - A=0xFFFFFFFF, B=1 -> outLo=0xFFFFFFFF, outHi=0.
- Assert resetDiv asynchronously (mid-cycle) during CALC iteration 10 of A=100, B=7 -> outputs go to 0 immediately; no endDiv pulse; a fresh start with A=50, B=6 yields outLo=8, outHi=2.
- Busy and back-to-back handling:
  - pulse DoDiv with new operands during CALC -> ignored; the original result is unaffected.
  - hold DoDiv high with A=20, B=3 -> repeated results outLo=6, outHi=2 with endDiv pulses spaced 34 edges apart.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - sequential signed restoring divider, quotient on outLo, remainder on outHi
// One quotient bit per cycle on operand magnitudes, then a sign-fix cycle.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetDiv,
    input  logic             DoDiv,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             endDiv,
    output logic             divZero,
    output logic [WIDTH-1:0] outHi,
    output logic [WIDTH-1:0] outLo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            end_q, end_d;
    logic            dz_q, dz_d;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    // Magnitudes wrap in WIDTH bits, so the most negative value maps to itself as unsigned.
    assign abs_a = A[WIDTH-1] ? -A : A;
    assign abs_b = B[WIDTH-1] ? -B : B;

    // rem_q stays below the divisor (at most 2^(WIDTH-1)), so WIDTH+1 bits hold the shifted value.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dsr_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        end_d   = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (DoDiv) begin
                    if (B == '0) begin
                        dz_d = ~dz_q;
                    end else begin
                        quo_d   = abs_a;
                        dsr_d   = abs_b;
                        rem_d   = '0;
                        cnt_d   = '0;
                        qneg_d  = A[WIDTH-1] ^ B[WIDTH-1];
                        rneg_d  = A[WIDTH-1];
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = qneg_q ? -quo_q : quo_q;
                hi_d    = rneg_q ? -rem_q : rem_q;
                end_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge resetDiv) begin
        if (resetDiv) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            end_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            end_q   <= end_d;
            dz_q    <= dz_d;
        end
    end

    assign endDiv  = end_q;
    assign divZero = dz_q;
    assign outHi   = hi_q;
    assign outLo   = lo_q;

endmodule
